// File: rtl/csr_uart_pkg.sv
// Shared definitions for the CSR-mapped UART receive peripheral family.
// Holds the receiver state type, the empty-buffer read value and the default CSR address.
package csr_uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_rx_state_e;

  localparam logic [31:0] EmptyRdata     = 32'hFFFF_FFFF;
  localparam logic [11:0] DefaultCsrAddr = 12'hBC0;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to ResetVal.
module sync2 #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ff1_q <= ResetVal;
      ff2_q <= ResetVal;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/csr_uart_rx.sv
// 8N1 serial receiver with a one-byte buffer exposed as a read-only CSR.
// Reading a full buffer empties it and clears the overrun/framing flags.
module csr_uart_rx
  import csr_uart_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR    = DefaultCsrAddr,
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx
);

  localparam logic [15:0] HalfLoad = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FullLoad = 16'(CLKS_PER_BIT - 1);

  // This block is read-only; writes are accepted and dropped.
  logic unused_inputs;
  assign unused_inputs = ^{modify, wdata};

  logic rx_sync;

  sync2 #(
    .ResetVal(1'b1)
  ) u_rx_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_sync)
  );

  uart_rx_state_e state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_store;
  logic        frame_ferr;
  logic        timer_exp;

  assign timer_exp = (timer_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_store = 1'b0;
    frame_ferr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_sync) begin
          state_d = StStart;
          timer_d = HalfLoad;
        end
      end
      StStart: begin
        if (timer_exp) begin
          if (!rx_sync) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
            timer_d   = FullLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StData: begin
        if (timer_exp) begin
          shift_d[bit_idx_q] = rx_sync;
          timer_d            = FullLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StStop: begin
        if (timer_exp) begin
          state_d = StIdle;
          if (rx_sync) begin
            frame_store = 1'b1;
          end else begin
            frame_ferr = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  logic [11:0] addr_q;
  logic        full_q, full_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        rd_hit;
  logic        rd_take;

  assign rd_hit  = read && (addr_q == BASE_ADDR);
  assign rd_take = rd_hit && full_q;

  always_comb begin
    // A read of a full buffer is applied first, so a byte landing on the same edge
    // refills an empty buffer and only its own frame events can set the flags.
    full_d  = full_q & ~rd_take;
    ovr_d   = ovr_q & ~rd_take;
    ferr_d  = ferr_q & ~rd_take;
    data_d  = data_q;
    if (frame_store) begin
      if (full_d) begin
        ovr_d = 1'b1;
      end
      data_d = shift_q;
      full_d = 1'b1;
    end
    if (frame_ferr) begin
      ferr_d = 1'b1;
    end
    valid_d = rd_hit;
    rdata_d = 32'd0;
    if (rd_hit) begin
      rdata_d = full_q ? {22'd0, ferr_q, ovr_q, data_q} : EmptyRdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 12'd0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= 8'd0;
      rdata_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_csr_uart_rx.sv
// Scoreboard bench for csr_uart_rx: serial frames and CSR reads are issued by a stimulus
// process, expected read data is queued from a buffer-level model and checked by a monitor.
module tb_csr_uart_rx;

  localparam int unsigned CPB  = 8;
  localparam logic [11:0] BASE = 12'hBC0;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic        rx;

  always #5 clk = ~clk;

  csr_uart_rx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .modify(modify),
    .wdata (wdata),
    .addr  (addr),
    .rdata (rdata),
    .valid (valid),
    .rx    (rx)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Buffer-level reference: one byte slot plus overrun and framing-error flags.
  bit         m_full, m_ovr, m_ferr;
  logic [7:0] m_byte;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read();
    logic [31:0] r;
    if (m_full) begin
      r = {22'd0, m_ferr, m_ovr, m_byte};
      m_full = 0;
      m_ovr  = 0;
      m_ferr = 0;
    end else begin
      r = 32'hFFFF_FFFF;
    end
    return r;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      if (m_full) m_ovr = 1;
      m_byte = b;
      m_full = 1;
    end else begin
      m_ferr = 1;
    end
  endfunction

  function automatic void model_reset();
    m_full = 0;
    m_ovr  = 0;
    m_ferr = 0;
    m_byte = 8'd0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", {31'd0, valid}, 32'd0);
        else check("rdata", rdata, exp_q.pop_front());
      end else begin
        check("rdata_idle_zero", rdata, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_read();
    exp_q.push_back(model_read());
    read = 1'b1;
    tick();
    read = 1'b0;
    tick();
  endtask

  // Drives one 8N1 frame; optionally places a CSR read on the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit rd_at_stop);
    logic [9:0] bits;
    int k;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int c = 0; c < int'(CPB); c++) begin
        tick();
        k = i * int'(CPB) + c + 1;
        if (rd_at_stop && k == 78) begin
          exp_q.push_back(model_read());
          read = 1'b1;
        end
        if (k == 79) read = 1'b0;
      end
    end
    rx = 1'b1;
    model_frame(b, stop_bit);
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) tick();
    idle(12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timed out");
  end

  initial begin
    int act;
    bit ok;
    rst    = 1'b1;
    read   = 1'b0;
    modify = 3'd0;
    wdata  = 32'd0;
    addr   = BASE;
    rx     = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    idle(4);

    // Single frame, then read twice.
    send_frame(8'h55, 1'b1, 1'b0);
    do_read();
    do_read();

    // Back-to-back frames without a read: overrun.
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    do_read();
    do_read();

    // Framing error held until the next stored byte.
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(16);
    send_frame(8'h3C, 1'b1, 1'b0);
    do_read();

    // Short low pulse is rejected.
    glitch(3);
    do_read();

    // Read coinciding with the stop sample of the next frame.
    send_frame(8'h77, 1'b1, 1'b0);
    send_frame(8'h88, 1'b1, 1'b1);
    do_read();

    // Reset in the middle of a frame.
    rx = 1'b0;
    repeat (3 * CPB) tick();
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    tick();
    check("midframe_reset_valid", {31'd0, valid}, 32'd0);
    tick();
    rst = 1'b0;
    idle(16);
    do_read();
    send_frame(8'h0F, 1'b1, 1'b0);
    do_read();

    // Writes and reads of another address must not be answered or disturb the buffer.
    send_frame(8'hC3, 1'b1, 1'b0);
    modify = 3'd1;
    wdata  = $urandom;
    repeat (3) tick();
    modify = 3'd0;
    addr   = BASE + 12'd1;
    tick();
    read = 1'b1;
    tick();
    read = 1'b0;
    addr = BASE;
    repeat (3) tick();
    do_read();

    // Randomized mix of frames, reads, glitches and ignored writes.
    for (int n = 0; n < 40; n++) begin
      act = $urandom_range(0, 9);
      if (act < 5) begin
        ok = ($urandom_range(0, 6) != 0);
        send_frame(8'($urandom), ok, ($urandom_range(0, 3) == 0));
        if (!ok) idle(12 + $urandom_range(0, 4));
        else idle($urandom_range(0, 4));
      end else if (act < 8) begin
        do_read();
      end else if (act == 8) begin
        glitch($urandom_range(1, 3));
      end else begin
        modify = 3'($urandom_range(1, 7));
        wdata  = $urandom;
        tick();
        modify = 3'd0;
        tick();
      end
    end
    do_read();

    idle(10);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
